// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: opcode + 0..MAX_OPERANDS operand fetch, then microstep walk until last_step/halt.
// Latency: 4 cycles per fetched byte plus one per memory wait cycle; strobes are Moore decodes of registered state.
// Backpressure: mem_ready stalls S_READ_BYTE; optional SINGLE_STEP_EN adds step_req to gate execute progress.
module fetch_sequencer #(
    parameter int MAX_OPERANDS = 2,
    parameter int MS_COUNT     = 8,
    parameter int MS_W         = $clog2(MS_COUNT),
    parameter int IDX_W        = $clog2(MAX_OPERANDS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_ready,
    input  logic [IDX_W:0]          operand_count,
    input  logic                    last_step,
    input  logic                    halt,
`ifdef SINGLE_STEP_EN
    input  logic                    step_req,
`endif
    output logic [2:0]              state,
    output logic                    load_origin,
    output logic                    load_mar_pc,
    output logic                    mem_rd,
    output logic                    load_ir,
    output logic [MAX_OPERANDS-1:0] load_operand,
    output logic                    pc_enable,
    output logic                    exec_en,
    output logic [MS_W-1:0]         microstep,
    output logic                    halted,
    output logic                    ucode_err
);

    typedef enum logic [2:0] {
        S_RESET          = 3'd0,
        S_INIT           = 3'd1,
        S_LATCH_ADDR     = 3'd2,
        S_READ_BYTE      = 3'd3,
        S_LATCH_BYTE     = 3'd4,
        S_CHK_MORE_BYTES = 3'd5,
        S_EXECUTE        = 3'd6,
        S_HALT           = 3'd7
    } fsm_state_t;

    fsm_state_t       cur_state;
    fsm_state_t       nxt_state;
    logic [IDX_W-1:0] byte_idx;
    logic [MS_W-1:0]  ms_q;
    logic             err_q;
    logic             advance;
    logic             clamp;
    logic [IDX_W:0]   eff_count;
    logic             more_bytes;
    logic             ms_last;

`ifdef SINGLE_STEP_EN
    assign advance = step_req;
`else
    assign advance = 1'b1;
`endif

    // Decoder may request more operands than the datapath holds; fetch only what fits and flag it.
    assign clamp      = operand_count > (IDX_W+1)'(MAX_OPERANDS);
    assign eff_count  = clamp ? (IDX_W+1)'(MAX_OPERANDS) : operand_count;
    assign more_bytes = {1'b0, byte_idx} < eff_count;
    assign ms_last    = ms_q == MS_W'(MS_COUNT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_RESET;
            byte_idx  <= '0;
            ms_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            case (cur_state)
                S_INIT: begin
                    byte_idx <= '0;
                    ms_q     <= '0;
                end
                S_CHK_MORE_BYTES: begin
                    if (clamp)
                        err_q <= 1'b1;
                    if (more_bytes)
                        byte_idx <= byte_idx + IDX_W'(1);
                    else
                        ms_q <= '0;
                end
                S_EXECUTE: begin
                    // Running off the end of the microstep space forces a return rather than wrapping.
                    if (advance && !halt && !last_step) begin
                        if (ms_last)
                            err_q <= 1'b1;
                        else
                            ms_q <= ms_q + MS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_RESET:          nxt_state = S_INIT;
            S_INIT:           nxt_state = S_LATCH_ADDR;
            S_LATCH_ADDR:     nxt_state = S_READ_BYTE;
            S_READ_BYTE:      nxt_state = mem_ready ? S_LATCH_BYTE : S_READ_BYTE;
            S_LATCH_BYTE:     nxt_state = S_CHK_MORE_BYTES;
            S_CHK_MORE_BYTES: nxt_state = more_bytes ? S_LATCH_ADDR : S_EXECUTE;
            S_EXECUTE: begin
                if (advance) begin
                    if (halt)
                        nxt_state = S_HALT;
                    else if (last_step || ms_last)
                        nxt_state = S_INIT;
                end
            end
            S_HALT:           nxt_state = S_HALT;
            default:          nxt_state = S_RESET;
        endcase
    end

    always_comb begin
        load_origin  = (cur_state == S_RESET);
        load_mar_pc  = (cur_state == S_LATCH_ADDR);
        mem_rd       = (cur_state == S_READ_BYTE);
        pc_enable    = (cur_state == S_LATCH_BYTE);
        load_ir      = (cur_state == S_LATCH_BYTE) && (byte_idx == '0);
        load_operand = '0;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            if ((cur_state == S_LATCH_BYTE) && (int'(byte_idx) == k + 1))
                load_operand[k] = 1'b1;
        end
        exec_en      = (cur_state == S_EXECUTE) && advance;
        halted       = (cur_state == S_HALT);
    end

    assign state     = cur_state;
    assign microstep = ms_q;
    assign ucode_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle-by-cycle vector table plus hand sequences for
// wait-states, operand clamping, forced return, halt priority and mid-fetch reset.
module tb_fetch_sequencer;

    localparam int ST_RESET = 0, ST_INIT = 1, ST_LA = 2, ST_RD = 3,
                   ST_LB = 4, ST_CHK = 5, ST_EXEC = 6, ST_HALT = 7;

    // Strobe vector bits: {load_origin, load_mar_pc, mem_rd, load_ir, load_operand[1:0], pc_enable, exec_en, halted, ucode_err}
    localparam logic [9:0] B_LO = 10'h200, B_LMP = 10'h100, B_RD = 10'h080, B_LIR = 10'h040,
                           B_OP1 = 10'h020, B_OP0 = 10'h010, B_PCE = 10'h008, B_EX = 10'h004,
                           B_HLT = 10'h002, B_ERR = 10'h001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b1;
    logic [2:0] operand_count = '0;
    logic       last_step = 1'b0;
    logic       halt = 1'b0;
`ifdef SINGLE_STEP_EN
    logic       step_req = 1'b1;
`endif
    logic [2:0] state;
    logic       load_origin, load_mar_pc, mem_rd, load_ir, pc_enable, exec_en, halted, ucode_err;
    logic [1:0] load_operand;
    logic [2:0] microstep;

    int tests = 0;
    int fails = 0;

    fetch_sequencer #(.MAX_OPERANDS(2), .MS_COUNT(8)) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .operand_count(operand_count),
        .last_step(last_step), .halt(halt),
`ifdef SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .state(state), .load_origin(load_origin), .load_mar_pc(load_mar_pc), .mem_rd(mem_rd),
        .load_ir(load_ir), .load_operand(load_operand), .pc_enable(pc_enable), .exec_en(exec_en),
        .microstep(microstep), .halted(halted), .ucode_err(ucode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       mrdy;
        logic [2:0] opc;
        logic       ls;
        logic       hl;
        int         st;
        int         ms;
        logic [9:0] strb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] strobes();
        return {load_origin, load_mar_pc, mem_rd, load_ir, load_operand, pc_enable, exec_en, halted, ucode_err};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic add(input logic r, input logic m, input logic [2:0] o, input logic l, input logic h,
                       input int st, input int ms, input logic [9:0] sb);
        vecs.push_back('{rst: r, mrdy: m, opc: o, ls: l, hl: h, st: st, ms: ms, strb: sb});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; operand_count = '0; last_step = 1'b0; halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction with mem_ready=1 until execute is left; last_step/halt fire at the given microstep.
    task automatic run_instr(input logic [2:0] opc, input int ls_at, input int hl_at,
                             output int fetch_cyc, output int ex_cnt, output int op0, output int op1,
                             output int ms_bad, output int err_in_exec, output int end_state);
        bit started, left;
        started = 0; left = 0;
        fetch_cyc = 0; ex_cnt = 0; op0 = 0; op1 = 0; ms_bad = 0; err_in_exec = 0; end_state = -1;
        for (int c = 0; c < 80 && !left; c++) begin
            @(negedge clk);
            mem_ready = 1'b1;
            operand_count = opc;
            last_step = (int'(state) == ST_EXEC) && (int'(microstep) == ls_at);
            halt      = (int'(state) == ST_EXEC) && (int'(microstep) == hl_at);
            #1;
            if (int'(state) == ST_LA) started = 1;
            op0 += int'(load_operand[0]);
            op1 += int'(load_operand[1]);
            if (int'(state) == ST_EXEC) begin
                if (int'(microstep) != ex_cnt) ms_bad++;
                if (ucode_err) err_in_exec = 1;
                ex_cnt++;
            end else if (ex_cnt > 0) begin
                left = 1;
                end_state = int'(state);
            end else if (started) begin
                fetch_cyc++;
            end
        end
        last_step = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        int fc, ex, o0, o1, mb, ee, es;
        int cyc, rd_cnt, run, maxrun, op0, op1, pce, irc, waits, bad;
        bit started, done;

        // Reset, opcode with no operands and last_step at MS2, then a two-operand opcode with minimum execute.
        add(1, 1, 0, 0, 0, ST_RESET, 0, B_LO);
        add(0, 1, 0, 0, 0, ST_RESET, 0, B_LO);
        add(0, 1, 0, 0, 0, ST_INIT,  0, 10'h0);
        add(0, 1, 0, 0, 0, ST_LA,    0, B_LMP);
        add(0, 1, 0, 0, 0, ST_RD,    0, B_RD);
        add(0, 1, 0, 0, 0, ST_LB,    0, B_LIR | B_PCE);
        add(0, 1, 0, 0, 0, ST_CHK,   0, 10'h0);
        add(0, 1, 0, 0, 0, ST_EXEC,  0, B_EX);
        add(0, 1, 0, 0, 0, ST_EXEC,  1, B_EX);
        add(0, 1, 0, 1, 0, ST_EXEC,  2, B_EX);
        add(0, 1, 2, 0, 0, ST_INIT,  2, 10'h0);
        add(0, 0, 2, 0, 0, ST_LA,    0, B_LMP);
        add(0, 1, 2, 0, 0, ST_RD,    0, B_RD);
        add(0, 1, 2, 0, 0, ST_LB,    0, B_LIR | B_PCE);
        add(0, 1, 2, 0, 0, ST_CHK,   0, 10'h0);
        add(0, 1, 2, 0, 0, ST_LA,    0, B_LMP);
        add(0, 1, 2, 0, 0, ST_RD,    0, B_RD);
        add(0, 1, 2, 0, 0, ST_LB,    0, B_OP0 | B_PCE);
        add(0, 1, 2, 0, 0, ST_CHK,   0, 10'h0);
        add(0, 1, 2, 0, 0, ST_LA,    0, B_LMP);
        add(0, 1, 2, 0, 0, ST_RD,    0, B_RD);
        add(0, 1, 2, 0, 0, ST_LB,    0, B_OP1 | B_PCE);
        add(0, 1, 2, 0, 0, ST_CHK,   0, 10'h0);
        add(0, 1, 2, 1, 0, ST_EXEC,  0, B_EX);
        add(0, 1, 0, 0, 0, ST_INIT,  0, 10'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; mem_ready = vecs[i].mrdy; operand_count = vecs[i].opc;
            last_step = vecs[i].ls; halt = vecs[i].hl;
            #1;
            chk($sformatf("vec%0d state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d microstep", i), int'(microstep), vecs[i].ms);
            chk($sformatf("vec%0d strobes", i), int'(strobes()), int'(vecs[i].strb));
        end

        // Three wait cycles on operand byte 1.
        do_reset();
        cyc = 0; rd_cnt = 0; run = 0; maxrun = 0; op0 = 0; op1 = 0; pce = 0; irc = 0; waits = 3;
        started = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            operand_count = 3'd1; last_step = 1'b1; halt = 1'b0;
            if (int'(state) == ST_RD && irc > 0 && waits > 0) begin
                mem_ready = 1'b0; waits--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (int'(state) == ST_LA) started = 1;
            if (int'(state) == ST_EXEC) done = 1;
            else if (started) cyc++;
            rd_cnt += int'(mem_rd);
            run = mem_rd ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            op0 += int'(load_operand[0]); op1 += int'(load_operand[1]);
            pce += int'(pc_enable); irc += int'(load_ir);
        end
        chk("wait reached execute", int'(done), 1);
        chk("wait fetch cycles", cyc, 11);
        chk("wait mem_rd cycles", rd_cnt, 5);
        chk("wait mem_rd run", maxrun, 4);
        chk("wait load_ir count", irc, 1);
        chk("wait load_operand0", op0, 1);
        chk("wait load_operand1", op1, 0);
        chk("wait pc_enable", pce, 2);
        mem_ready = 1'b1;

        // No last_step: forced return after microstep 7 flags ucode_err.
        do_reset();
        run_instr(3'd0, -1, -1, fc, ex, o0, o1, mb, ee, es);
        chk("force fetch cycles", fc, 4);
        chk("force exec cycles", ex, 8);
        chk("force microstep order", mb, 0);
        chk("force err during exec", ee, 0);
        chk("force end state", es, ST_INIT);
        chk("force ucode_err", int'(ucode_err), 1);

        // Operand count above the limit is clamped and flags ucode_err.
        do_reset();
        run_instr(3'd3, 2, -1, fc, ex, o0, o1, mb, ee, es);
        chk("clamp fetch cycles", fc, 12);
        chk("clamp operand0 loads", o0, 1);
        chk("clamp operand1 loads", o1, 1);
        chk("clamp err in exec", ee, 1);
        chk("clamp exec cycles", ex, 3);
        run_instr(3'd0, 0, -1, fc, ex, o0, o1, mb, ee, es);
        chk("clamp err sticky", ee, 1);

        // Reset arriving mid-read with memory stalled aborts immediately and clears ucode_err.
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            operand_count = 3'd0; mem_ready = 1'b0;
            #1;
            if (int'(state) == ST_RD) done = 1;
        end
        chk("midreset reached read", int'(done), 1);
        #2 reset = 1'b1;
        #1;
        chk("midreset state", int'(state), ST_RESET);
        chk("midreset strobes", int'(strobes()), int'(B_LO));
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;

        // Halt and last_step together at MS1: halt wins and the core stays parked.
        run_instr(3'd0, 1, 1, fc, ex, o0, o1, mb, ee, es);
        chk("halt exec cycles", ex, 2);
        chk("halt end state", es, ST_HALT);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_ready = 1'b1; last_step = 1'b1; operand_count = 3'd1;
            #1;
            if (int'(state) != ST_HALT || strobes() != B_HLT) bad++;
        end
        chk("halt parked cycles bad", bad, 0);
        last_step = 1'b0;

`ifdef SINGLE_STEP_EN
        do_reset();
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            step_req = 1'b1; operand_count = 3'd0;
            #1;
            if (int'(state) == ST_EXEC) done = 1;
        end
        chk("step reached execute", int'(done), 1);
        begin
            int exp_ms = 0;
            for (int k = 0; k < 9; k++) begin
                if (k > 0) @(negedge clk);
                step_req = (k % 3 == 0);
                #1;
                chk($sformatf("step%0d microstep", k), int'(microstep), exp_ms);
                chk($sformatf("step%0d exec_en", k), int'(exec_en), int'(step_req));
                if (step_req) exp_ms++;
            end
        end
        step_req = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
